// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared widths, result-class codes and unpacked-operand bundle for FP_Div.
package fp_div_pkg;
   localparam int EXP_W    = 8;
   localparam int MAN_W    = 23;
   localparam int FP_W     = 1 + EXP_W + MAN_W;
   localparam int EXP_BIAS = 127;
   localparam logic [1:0] CLS_NORMAL = 2'd0;
   localparam logic [1:0] CLS_NAN    = 2'd1;
   localparam logic [1:0] CLS_INF    = 2'd2;
   localparam logic [1:0] CLS_ZERO   = 2'd3;
   typedef struct packed {
      logic [FP_W-1:0]  num_a;
      logic [FP_W-1:0]  num_b;
      logic             sign;
      logic [EXP_W-1:0] exp_a;
      logic [EXP_W-1:0] exp_b;
      logic [MAN_W:0]   man_a;
      logic [MAN_W:0]   man_b;
      logic [1:0]       cls;
      logic             dbz;
   } fp_div_op_t;
endpackage

// File: rtl/fp_operand_classify.sv
// fp_operand_classify: decodes one operand's exponent/fraction into special-case flags and a 24-bit mantissa.
module fp_operand_classify #(
   parameter bit DAZ   = 1'b1,
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic [EXP_W+MAN_W-1:0] num_i,
   output logic                   is_nan_o,
   output logic                   is_inf_o,
   output logic                   is_zero_o,
   output logic                   is_denorm_o,
   output logic [EXP_W-1:0]       exp_o,
   output logic [MAN_W:0]         man_o
);
   logic [EXP_W-1:0] e;
   logic [MAN_W-1:0] f;
   logic e_max, e_zero, f_zero;
   assign e      = num_i[EXP_W+MAN_W-1:MAN_W];
   assign f      = num_i[MAN_W-1:0];
   assign e_max  = &e;
   assign e_zero = ~|e;
   assign f_zero = ~|f;
   assign is_nan_o    = e_max & ~f_zero;
   assign is_inf_o    = e_max & f_zero;
   assign is_zero_o   = e_zero & f_zero;
   assign is_denorm_o = e_zero & ~f_zero;
   // Without DAZ a denormal keeps its fraction and takes the minimum biased exponent.
   assign exp_o = is_denorm_o ? (DAZ ? '0 : EXP_W'(1)) : e;
   assign man_o = (is_denorm_o & DAZ) ? '0 : {~e_zero, f};
endmodule

// File: rtl/fp_div_operand_stage.sv
// fp_div_operand_stage: registered skid-buffered unpack/classify stage feeding FP_Div.
module fp_div_operand_stage
   import fp_div_pkg::*;
#(
   parameter bit DAZ   = 1'b1,
   parameter int EXP_W = fp_div_pkg::EXP_W,
   parameter int MAN_W = fp_div_pkg::MAN_W
) (
   input  logic                 in_clk,
   input  logic                 in_rst_n,
   input  logic                 in_valid,
   input  logic [EXP_W+MAN_W:0] in_numA,
   input  logic [EXP_W+MAN_W:0] in_numB,
   output logic                 out_ready,
   output logic                 out_valid,
   input  logic                 in_ready,
   output logic [EXP_W+MAN_W:0] out_numA,
   output logic [EXP_W+MAN_W:0] out_numB,
   output logic                 out_sign,
   output logic [EXP_W-1:0]     out_expA,
   output logic [EXP_W-1:0]     out_expB,
   output logic [MAN_W:0]       out_manA,
   output logic [MAN_W:0]       out_manB,
   output logic [1:0]           out_class,
   output logic                 out_dbz
);
   localparam int W = 1 + EXP_W + MAN_W;
   logic a_nan, a_inf, a_zero, a_den, b_nan, b_inf, b_zero, b_den;
   logic a_z, b_z, nan;
   logic [EXP_W-1:0] a_exp, b_exp;
   logic [MAN_W:0] a_man, b_man;
   fp_div_op_t cur, main_q, main_d, skid_q, skid_d;
   logic main_v_q, main_v_d, skid_v_q, skid_v_d;
   logic up, main_load;
   fp_operand_classify #(.DAZ(DAZ), .EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
      .num_i(in_numA[W-2:0]), .is_nan_o(a_nan), .is_inf_o(a_inf), .is_zero_o(a_zero),
      .is_denorm_o(a_den), .exp_o(a_exp), .man_o(a_man)
   );
   fp_operand_classify #(.DAZ(DAZ), .EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
      .num_i(in_numB[W-2:0]), .is_nan_o(b_nan), .is_inf_o(b_inf), .is_zero_o(b_zero),
      .is_denorm_o(b_den), .exp_o(b_exp), .man_o(b_man)
   );
   assign a_z = a_zero | (DAZ & a_den);
   assign b_z = b_zero | (DAZ & b_den);
   assign nan = a_nan | b_nan | (a_z & b_z) | (a_inf & b_inf);
   always_comb begin
      cur       = '0;
      cur.num_a = in_numA;
      cur.num_b = in_numB;
      cur.sign  = in_numA[W-1] ^ in_numB[W-1];
      cur.exp_a = a_exp;
      cur.exp_b = b_exp;
      cur.man_a = a_man;
      cur.man_b = b_man;
      cur.cls   = nan ? CLS_NAN : (a_inf | b_z) ? CLS_INF : (a_z | b_inf) ? CLS_ZERO : CLS_NORMAL;
      cur.dbz   = b_z & ~(a_nan | a_inf | a_z);
   end
   // out_ready depends only on skid occupancy, so in_ready never reaches it combinationally.
   assign out_ready = ~skid_v_q;
   assign up        = in_valid & out_ready;
   assign main_load = ~main_v_q | in_ready;
   always_comb begin
      main_d   = main_load ? (skid_v_q ? skid_q : (up ? cur : main_q)) : main_q;
      main_v_d = main_load ? (skid_v_q | up) : 1'b1;
      skid_d   = (~skid_v_q & up & ~main_load) ? cur : skid_q;
      skid_v_d = skid_v_q ? ~main_load : (up & ~main_load);
   end
   always_ff @(posedge in_clk) begin
      if (!in_rst_n) begin
         main_q   <= '0;
         skid_q   <= '0;
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
      end else begin
         main_q   <= main_d;
         skid_q   <= skid_d;
         main_v_q <= main_v_d;
         skid_v_q <= skid_v_d;
      end
   end
   assign out_valid = main_v_q;
   assign out_numA  = main_q.num_a;
   assign out_numB  = main_q.num_b;
   assign out_sign  = main_q.sign;
   assign out_expA  = main_q.exp_a;
   assign out_expB  = main_q.exp_b;
   assign out_manA  = main_q.man_a;
   assign out_manB  = main_q.man_b;
   assign out_class = main_q.cls;
   assign out_dbz   = main_q.dbz;
endmodule

// File: tb/tb_fp_div_operand_stage.sv
// tb_fp_div_operand_stage: directed vectors, back-pressure, streaming and reset checks for the operand stage.
module tb_fp_div_operand_stage;
   logic clk = 1'b0, rst_n, in_valid, in_ready;
   logic [31:0] a, b;
   logic o_ready, o_valid, o_sign, o_dbz, o0_ready, o0_valid, o0_sign, o0_dbz;
   logic [31:0] o_numA, o_numB, o0_numA, o0_numB;
   logic [7:0] o_expA, o_expB, o0_expA, o0_expB;
   logic [23:0] o_manA, o_manB, o0_manA, o0_manB;
   logic [1:0] o_class, o0_class;
   logic [131:0] o_all, o0_all;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   fp_div_operand_stage #(.DAZ(1'b1)) dut (
      .in_clk(clk), .in_rst_n(rst_n), .in_valid(in_valid), .in_numA(a), .in_numB(b),
      .out_ready(o_ready), .out_valid(o_valid), .in_ready(in_ready),
      .out_numA(o_numA), .out_numB(o_numB), .out_sign(o_sign), .out_expA(o_expA), .out_expB(o_expB),
      .out_manA(o_manA), .out_manB(o_manB), .out_class(o_class), .out_dbz(o_dbz)
   );
   fp_div_operand_stage #(.DAZ(1'b0)) dut0 (
      .in_clk(clk), .in_rst_n(rst_n), .in_valid(in_valid), .in_numA(a), .in_numB(b),
      .out_ready(o0_ready), .out_valid(o0_valid), .in_ready(in_ready),
      .out_numA(o0_numA), .out_numB(o0_numB), .out_sign(o0_sign), .out_expA(o0_expA), .out_expB(o0_expB),
      .out_manA(o0_manA), .out_manB(o0_manB), .out_class(o0_class), .out_dbz(o0_dbz)
   );
   assign o_all  = {o_numA, o_numB, o_sign, o_expA, o_expB, o_manA, o_manB, o_class, o_dbz};
   assign o0_all = {o0_numA, o0_numB, o0_sign, o0_expA, o0_expB, o0_manA, o0_manB, o0_class, o0_dbz};
   typedef struct {
      logic [31:0] a, b;
      logic [1:0]  cls;
      logic        sign;
      logic [7:0]  ea, eb;
      logic [23:0] ma, mb;
      logic        dbz;
   } vec_t;
   vec_t vt[12];
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask
   function automatic logic [131:0] ref_out(input logic [31:0] x, input logic [31:0] y, input bit daz);
      logic [7:0] ex, ey, ox, oy;
      logic [22:0] fx, fy;
      logic [23:0] mx, my;
      logic nx, ny, ix, iy, zx, zy, d;
      logic [1:0] c;
      ex = x[30:23]; fx = x[22:0]; ey = y[30:23]; fy = y[22:0];
      nx = (ex == 8'hFF) && (fx != 0); ix = (ex == 8'hFF) && (fx == 0);
      ny = (ey == 8'hFF) && (fy != 0); iy = (ey == 8'hFF) && (fy == 0);
      zx = (ex == 0) && ((fx == 0) || daz); zy = (ey == 0) && ((fy == 0) || daz);
      if (ex != 0) begin ox = ex; mx = {1'b1, fx}; end
      else if (daz || fx == 0) begin ox = 0; mx = 0; end
      else begin ox = 8'd1; mx = {1'b0, fx}; end
      if (ey != 0) begin oy = ey; my = {1'b1, fy}; end
      else if (daz || fy == 0) begin oy = 0; my = 0; end
      else begin oy = 8'd1; my = {1'b0, fy}; end
      d = 1'b0;
      if (nx || ny || (zx && zy) || (ix && iy)) c = 2'd1;
      else if (ix) c = 2'd2;
      else if (zy) begin c = 2'd2; d = 1'b1; end
      else if (zx || iy) c = 2'd3;
      else c = 2'd0;
      return {x, y, x[31] ^ y[31], ox, oy, mx, my, c, d};
   endfunction
   function automatic logic [31:0] rnd_fp();
      int r;
      logic [7:0] e;
      logic [22:0] f;
      r = $urandom_range(0, 7);
      f = (r == 1) ? 23'd0 : 23'($urandom);
      e = (r < 2) ? 8'h00 : (r < 4) ? 8'hFF : 8'($urandom_range(1, 254));
      return {1'($urandom), e, f};
   endfunction
   initial begin
      int sent, cyc;
      logic up, dn;
      logic [131:0] snap;
      logic [131:0] q[$];
      vt[0]  = '{32'h3F800000, 32'h40000000, 2'd0, 1'b0, 8'h7F, 8'h80, 24'h800000, 24'h800000, 1'b0};
      vt[1]  = '{32'h7FC00000, 32'h3F800000, 2'd1, 1'b0, 8'hFF, 8'h7F, 24'hC00000, 24'h800000, 1'b0};
      vt[2]  = '{32'h3F800000, 32'h00000000, 2'd2, 1'b0, 8'h7F, 8'h00, 24'h800000, 24'h000000, 1'b1};
      vt[3]  = '{32'h00000000, 32'h80000000, 2'd1, 1'b1, 8'h00, 8'h00, 24'h000000, 24'h000000, 1'b0};
      vt[4]  = '{32'hBF800000, 32'h7F800000, 2'd3, 1'b1, 8'h7F, 8'hFF, 24'h800000, 24'h800000, 1'b0};
      vt[5]  = '{32'h00000001, 32'h3F800000, 2'd3, 1'b0, 8'h00, 8'h7F, 24'h000000, 24'h800000, 1'b0};
      vt[6]  = '{32'h7F800000, 32'hFF800000, 2'd1, 1'b1, 8'hFF, 8'hFF, 24'h800000, 24'h800000, 1'b0};
      vt[7]  = '{32'hFF800000, 32'h3F800000, 2'd2, 1'b1, 8'hFF, 8'h7F, 24'h800000, 24'h800000, 1'b0};
      vt[8]  = '{32'h7FC00000, 32'h00000000, 2'd1, 1'b0, 8'hFF, 8'h00, 24'hC00000, 24'h000000, 1'b0};
      vt[9]  = '{32'h40C00000, 32'h3FC00000, 2'd0, 1'b0, 8'h81, 8'h7F, 24'hC00000, 24'hC00000, 1'b0};
      vt[10] = '{32'h00000000, 32'h3F800000, 2'd3, 1'b0, 8'h00, 8'h7F, 24'h000000, 24'h800000, 1'b0};
      vt[11] = '{32'h3F800000, 32'h00400000, 2'd2, 1'b0, 8'h7F, 8'h00, 24'h800000, 24'h000000, 1'b1};
      rst_n = 1'b0; in_valid = 1'b0; in_ready = 1'b0; a = '0; b = '0;
      step(); step();
      rst_n = 1'b1;
      chk("reset_valid", o_valid, 0);
      chk("reset_ready", o_ready, 1);
      chk("reset_data", o_all, 0);
      in_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         a = vt[i].a; b = vt[i].b;
         step();
         chk($sformatf("vec%0d_valid", i), o_valid, 1);
         chk($sformatf("vec%0d_fields", i), o_all,
             {vt[i].a, vt[i].b, vt[i].sign, vt[i].ea, vt[i].eb, vt[i].ma, vt[i].mb, vt[i].cls, vt[i].dbz});
      end
      a = 32'h00000001; b = 32'h3F800000;
      step();
      chk("noDAZ_denA_class", o0_class, 0);
      chk("noDAZ_denA_exp", o0_expA, 8'h01);
      chk("noDAZ_denA_man", o0_manA, 24'h000001);
      a = 32'h3F800000; b = 32'h00400000;
      step();
      chk("noDAZ_denB", {o0_class, o0_expB, o0_manB, o0_dbz}, {2'd0, 8'h01, 24'h400000, 1'b0});
      in_valid = 1'b0;
      step();
      chk("idle_valid", o_valid, 0);
      in_ready = 1'b0; in_valid = 1'b1;
      a = 32'h3F800001; b = 32'h40000001;
      step();
      chk("bp1_valid", o_valid, 1);
      chk("bp1_ready", o_ready, 1);
      chk("bp1_data", o_numA, 32'h3F800001);
      a = 32'h3F800002; b = 32'h40000002;
      step();
      chk("bp2_ready", o_ready, 0);
      chk("bp2_hold", o_numA, 32'h3F800001);
      a = 32'h3F800003; b = 32'h40000003;
      step();
      chk("bp3_ready", o_ready, 0);
      chk("bp3_hold", o_all, ref_out(32'h3F800001, 32'h40000001, 1));
      in_ready = 1'b1;
      step();
      chk("bp_out2", o_all, ref_out(32'h3F800002, 32'h40000002, 1));
      chk("bp_ready_back", o_ready, 1);
      step();
      chk("bp_out3", o_all, ref_out(32'h3F800003, 32'h40000003, 1));
      chk("bp_out3_valid", o_valid, 1);
      in_valid = 1'b0;
      step();
      chk("bp_drained", o_valid, 0);
      sent = 0; cyc = 0;
      while ((sent < 100 || q.size() != 0 || o_valid) && cyc < 3000) begin
         in_ready = 1'($urandom_range(0, 1));
         in_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
         a = rnd_fp(); b = rnd_fp();
         up = in_valid & o_ready;
         dn = o_valid & in_ready;
         snap = o_all;
         step();
         if (dn) begin
            if (q.size() == 0) begin
               total++; bad++;
               $display("FAIL stream_extra got=%h want=none", snap);
            end else chk("stream", snap, q.pop_front());
         end
         if (up) begin
            q.push_back(ref_out(a, b, 1));
            sent++;
         end
         cyc++;
      end
      chk("stream_sent", sent, 100);
      chk("stream_left", q.size(), 0);
      in_valid = 1'b0;
      in_ready = 1'b0; in_valid = 1'b1;
      a = 32'h41000000; b = 32'h40400000;
      step();
      a = 32'h41100000; b = 32'h40800000;
      step();
      chk("rst_stall_ready", o_ready, 0);
      chk("rst_stall_valid", o_valid, 1);
      rst_n = 1'b0; in_valid = 1'b0;
      step();
      rst_n = 1'b1; in_ready = 1'b1;
      chk("rst_mid_valid", o_valid, 0);
      chk("rst_mid_ready", o_ready, 1);
      chk("rst_mid_data", o_all, 0);
      step();
      chk("rst_after_valid1", o_valid, 0);
      step();
      chk("rst_after_valid2", o_valid, 0);
      chk("rst_after_ready", o_ready, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
